// File: rtl/cd_pkg.sv
// Shared CD-ROM definitions: sector RAM geometry, sector mode, loader state
// encoding and the per-mode start offsets and lengths.
package cd_pkg;

  localparam int unsigned SECTOR_RAM_ADDR_W = 12;
  localparam int unsigned OFFS_DATA         = 24;
  localparam int unsigned OFFS_RAW          = 12;
  localparam int unsigned LEN_DATA          = 2048;
  localparam int unsigned LEN_RAW           = 2340;
  localparam int unsigned CNT_W             = 12;

  typedef enum logic {
    SECT_DATA = 1'b0,
    SECT_RAW  = 1'b1
  } cd_sector_mode_t;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WAIT_SECT,
    LD_FETCH,
    LD_WRITE,
    LD_DONE
  } cd_loader_state_t;

endpackage

// File: rtl/cd_loader_skid.sv
// One-entry hold register between sector RAM read data and the FIFO write
// port; a freshly returned byte bypasses the register when nothing is held.
module cd_loader_skid (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       load,
  input  logic       take,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       avail
);

  logic [7:0] hold;
  logic       hold_valid;

  always_comb begin
    avail = hold_valid | load;
    dout  = (load && !hold_valid) ? din : hold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (flush)     hold_valid <= 1'b0;
      else if (load) hold_valid <= hold_valid | ~take;
      else if (take) hold_valid <= 1'b0;
      // A held byte that is not consumed this cycle must not be overwritten.
      if (load && !(hold_valid && !take)) hold <= din;
    end
  end

endmodule

// File: rtl/cd_sector_loader.sv
// Copies the user bytes of one buffered sector from sector RAM into the data
// FIFO. Define CD_LOADER_PIPE_EN for the overlapped 1 byte/cycle variant.
module cd_sector_loader #(
  parameter int unsigned ADDR_W    = cd_pkg::SECTOR_RAM_ADDR_W,
  parameter int unsigned OFFS_DATA = cd_pkg::OFFS_DATA,
  parameter int unsigned OFFS_RAW  = cd_pkg::OFFS_RAW,
  parameter int unsigned LEN_DATA  = cd_pkg::LEN_DATA,
  parameter int unsigned LEN_RAW   = cd_pkg::LEN_RAW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              want_data,
  input  logic              abort,
  input  logic              size_sel,
  input  logic [ADDR_W-1:0] sector_base,
  input  logic              sector_ready,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              fifo_we,
  output logic [7:0]        fifo_data,
  output logic              fifo_clr,
  input  logic              fifo_full,
  output logic              busy,
  output logic              done
);

  import cd_pkg::*;

  cd_loader_state_t  state, state_nxt;
  cd_sector_mode_t   mode;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  count, len_m1;
  logic              rd_valid, clr, start, kill, last, load, avail;
  logic [7:0]        skid_data;

`ifdef CD_LOADER_PIPE_EN
  logic [CNT_W-1:0]  issued, len;
  logic              issue_ok;

  assign len      = len_m1 + CNT_W'(1);
  // A read already in flight always fits: it either writes or parks in the skid.
  assign issue_ok = (issued != len) && !fifo_full && !abort;
`endif

  assign len_m1 = (mode == SECT_RAW) ? CNT_W'(LEN_RAW - 1) : CNT_W'(LEN_DATA - 1);
  assign start  = (state == LD_IDLE) && want_data && !abort;
  assign kill   = (state != LD_IDLE) && abort;
  assign last   = (count == len_m1);
  assign load   = rd_valid && (state != LD_IDLE);

  assign ram_addr  = addr;
  assign fifo_data = skid_data;
  assign fifo_clr  = clr;

  cd_loader_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush ((state == LD_IDLE) || abort),
    .load  (load),
    .take  (fifo_we),
    .din   (ram_data),
    .dout  (skid_data),
    .avail (avail)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = LD_IDLE;
    end else begin
      case (state)
        LD_IDLE:      if (start) state_nxt = LD_WAIT_SECT;
        LD_WAIT_SECT: if (sector_ready) state_nxt = LD_FETCH;
`ifdef CD_LOADER_PIPE_EN
        LD_FETCH:     if (fifo_we && last) state_nxt = LD_DONE;
`else
        LD_FETCH:     state_nxt = LD_WRITE;
        LD_WRITE:     if (fifo_we) state_nxt = last ? LD_DONE : LD_FETCH;
`endif
        LD_DONE:      state_nxt = LD_IDLE;
        default:      state_nxt = LD_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_re  = 1'b0;
    fifo_we = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      LD_WAIT_SECT: busy = 1'b1;
`ifdef CD_LOADER_PIPE_EN
      LD_FETCH: begin
        busy    = 1'b1;
        ram_re  = issue_ok;
        fifo_we = avail && !fifo_full && !abort;
      end
`else
      LD_FETCH: begin
        busy   = 1'b1;
        ram_re = !abort;
      end
      LD_WRITE: begin
        busy    = 1'b1;
        fifo_we = avail && !fifo_full && !abort;
      end
`endif
      LD_DONE:  done = !abort;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode     <= SECT_DATA;
      addr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      clr      <= 1'b0;
`ifdef CD_LOADER_PIPE_EN
      issued   <= '0;
`endif
    end else begin
      clr      <= start || kill;
      rd_valid <= ram_re;
      if (start) begin
        mode  <= size_sel ? SECT_RAW : SECT_DATA;
        addr  <= sector_base + (size_sel ? ADDR_W'(OFFS_RAW) : ADDR_W'(OFFS_DATA));
        count <= '0;
`ifdef CD_LOADER_PIPE_EN
        issued <= '0;
`endif
      end else begin
        if (ram_re)  addr  <= addr + ADDR_W'(1);
        if (fifo_we) count <= count + CNT_W'(1);
`ifdef CD_LOADER_PIPE_EN
        if (ram_re)  issued <= issued + CNT_W'(1);
`endif
      end
    end
  end

endmodule
